// File: rtl/fetch_stage_pkg.sv
// Shared pipeline-register bundles and constants
// for the instruction fetch front end.
package pipe_regs;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
  } fetch_state_t;

  typedef struct packed {
    logic stall;
    logic squash;
  } stage_ctrl_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO buffering fetched words
// with a single-cycle flush.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(i_push)
                     - CW'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order
// word reads and presents one instruction per cycle.
module fetch_stage
  import pipe_regs::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  stage_ctrl_t  stage_ctrl_i,
  input  logic         pc_set_i,
  input  logic [31:0]  pc_target_i,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  output logic         valid_o,
  output fetch_state_t fetch_state_o,
  output logic [31:0]  inst_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic         r_valid;
  fetch_state_t r_state;
  logic [31:0]  r_inst;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic [63:0]   w_head;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_out_nxt;
  logic [31:0]   w_target;
  logic [31:0]   w_hd_pc;
  logic [31:0]   w_hd_inst;
  logic w_issue, w_push, w_upd;
  logic w_avail, w_take;
  logic w_fifo_push, w_fifo_pop;

  assign w_inflight = {1'b0, r_outstanding}
                    + {1'b0, w_count};
  assign imem_req_o = rst_ni && !pc_set_i
    && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = r_fetch_pc;
  assign w_issue = imem_req_o && imem_gnt_i;

  assign w_out_nxt = r_outstanding
                   + CW'(w_issue)
                   - CW'(imem_rvalid_i);
  assign w_target = pc_target_i & ~32'h3;

  assign w_push = imem_rvalid_i && !pc_set_i
               && (r_discard == '0);
  assign w_upd = !stage_ctrl_i.stall
              && !stage_ctrl_i.squash
              && !pc_set_i;
  assign w_avail = !w_empty || w_push;
  assign w_take  = w_upd && w_avail;

  // An empty FIFO forwards the arriving word
  // straight into the output register.
  assign w_fifo_push = w_push
                    && !(w_empty && w_take);
  assign w_fifo_pop  = w_take && !w_empty;
  assign {w_hd_pc, w_hd_inst} = w_empty
    ? {r_resp_pc, imem_rdata_i} : w_head;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_fifo_push),
    .i_data  ({r_resp_pc, imem_rdata_i}),
    .i_pop   (w_fifo_pop),
    .i_flush (pc_set_i),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_fetch_pc    <= BOOT_ADDR;
      r_resp_pc     <= BOOT_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (pc_set_i) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_discard  <= w_out_nxt;
      end else begin
        if (w_issue)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)
          r_resp_pc <= r_resp_pc + 32'd4;
        if (imem_rvalid_i && r_discard != '0)
          r_discard <= r_discard - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_state <= '0;
      r_inst  <= NOP_INST;
    end else if (pc_set_i) begin
      r_valid <= 1'b0;
    end else if (!stage_ctrl_i.stall) begin
      if (w_take) begin
        r_valid         <= 1'b1;
        r_state.pc      <= w_hd_pc;
        r_state.next_pc <= w_hd_pc + 32'd4;
        r_inst          <= w_hd_inst;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_o       = r_valid;
  assign fetch_state_o = r_state;
  assign inst_o        = r_inst;

  ap_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (w_fifo_push && w_full) |-> w_fifo_pop
  );

endmodule
